input_conditioner: RTL and testbench

//  Front-end conditioning stage for board push-buttons/switches feeding the counter's count/clear.
//  Per channel: 2-flop synchroniser, debounce state machine, then a registered debounced

---
 rtl/input_cond_pkg.sv | 21 ++
 rtl/input_conditioner_debounce_channel.sv | 119 +++++++++++
 rtl/input_conditioner.sv | 35 +++
 tb/tb_input_conditioner.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/input_cond_pkg.sv
// Shared types and helpers for the input conditioner.
// Holds the per-channel debounce state encoding and the counter width helper.
package input_cond_pkg;

   typedef enum logic [1:0] {
      ST_LO  = 2'd0,
      CHK_HI = 2'd1,
      ST_HI  = 2'd2,
      CHK_LO = 2'd3
   } state_t;

   // Width of a counter that must hold the largest of the three limits.
   function automatic int cnt_w(input int a, input int b, input int c);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return $clog2(m + 1);
   endfunction

endpackage

// File: rtl/input_conditioner_debounce_channel.sv
// One conditioned channel: 2-flop synchroniser, debounce FSM, level/rise/fall.
// Ports: clock, clear (sync, active-high), raw -> level, rise, fall.
// Optional auto-repeat on rise while held: macro INPUT_COND_REPEAT_EN.
module debounce_channel
   import input_cond_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int REPEAT_DELAY    = 50000000,
   parameter int REPEAT_PERIOD   = 10000000
) (
   input  logic clock,
   input  logic clear,
   input  logic raw,
   output logic level,
   output logic rise,
   output logic fall
);

   localparam int CNT_W =
      cnt_w(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
   localparam logic [CNT_W-1:0] DB_LAST =
      CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             s1;
   logic             s2;
   state_t           state;
   logic [CNT_W-1:0] cnt;

`ifdef INPUT_COND_REPEAT_EN
   localparam logic [CNT_W-1:0] RD_LAST =
      CNT_W'(REPEAT_DELAY - 1);
   localparam logic [CNT_W-1:0] RP_LAST =
      CNT_W'(REPEAT_PERIOD - 1);
   // Set once the first (delayed) repeat has fired.
   logic rep;
`endif

   // In ST_HI the debounce counter is idle, so it doubles as the
   // repeat counter when auto-repeat is built in.
   always_ff @(posedge clock) begin
      if (clear) begin
         s1    <= 1'b0;
         s2    <= 1'b0;
         state <= ST_LO;
         cnt   <= '0;
         level <= 1'b0;
         rise  <= 1'b0;
         fall  <= 1'b0;
`ifdef INPUT_COND_REPEAT_EN
         rep   <= 1'b0;
`endif
      end else begin
         s1   <= raw;
         s2   <= s1;
         rise <= 1'b0;
         fall <= 1'b0;
         unique case (state)
            ST_LO: begin
               if (s2) begin
                  state <= CHK_HI;
                  cnt   <= '0;
               end
            end
            CHK_HI: begin
               if (!s2) begin
                  state <= ST_LO;
                  cnt   <= '0;
               end else if (cnt == DB_LAST) begin
                  state <= ST_HI;
                  level <= 1'b1;
                  rise  <= 1'b1;
                  cnt   <= '0;
`ifdef INPUT_COND_REPEAT_EN
                  rep   <= 1'b0;
`endif
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            ST_HI: begin
               if (!s2) begin
                  state <= CHK_LO;
                  cnt   <= '0;
               end
`ifdef INPUT_COND_REPEAT_EN
               else if (cnt == (rep ? RP_LAST : RD_LAST)) begin
                  rise <= 1'b1;
                  rep  <= 1'b1;
                  cnt  <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
`endif
            end
            CHK_LO: begin
               if (s2) begin
                  state <= ST_HI;
                  cnt   <= '0;
`ifdef INPUT_COND_REPEAT_EN
                  rep   <= 1'b0;
`endif
               end else if (cnt == DB_LAST) begin
                  state <= ST_LO;
                  level <= 1'b0;
                  fall  <= 1'b1;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               state <= ST_LO;
               cnt   <= '0;
            end
         endcase
      end
   end

endmodule

// File: rtl/input_conditioner.sv
// Conditions NUM_CH raw push-button/switch pins into debounced levels and pulses.
// Ports: clock, clear (sync, active-high), raw_i[NUM_CH] -> level_o, rise_o, fall_o.
// Macro INPUT_COND_REPEAT_EN adds auto-repeat rise pulses while a pin is held.
module input_conditioner
   import input_cond_pkg::*;
#(
   parameter int NUM_CH          = 2,
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int REPEAT_DELAY    = 50000000,
   parameter int REPEAT_PERIOD   = 10000000
) (
   input  logic              clock,
   input  logic              clear,
   input  logic [NUM_CH-1:0] raw_i,
   output logic [NUM_CH-1:0] level_o,
   output logic [NUM_CH-1:0] rise_o,
   output logic [NUM_CH-1:0] fall_o
);

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      debounce_channel #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
         .REPEAT_DELAY   (REPEAT_DELAY),
         .REPEAT_PERIOD  (REPEAT_PERIOD)
      ) u_ch (
         .clock(clock),
         .clear(clear),
         .raw  (raw_i[g]),
         .level(level_o[g]),
         .rise (rise_o[g]),
         .fall (fall_o[g])
      );
   end

endmodule

// File: tb/tb_input_conditioner.sv
// Self-checking bench for input_conditioner (DEBOUNCE_CYCLES=4, REPEAT 10/5).
// Directed tables and sequences plus randomized stimulus against a run-length model.
module tb_input_conditioner;

   localparam int D  = 4;
   localparam int RD = 10;
   localparam int RP = 5;

   logic       clock = 1'b0;
   logic       clear = 1'b1;
   logic [1:0] raw_i = 2'b00;
   logic [1:0] level_o;
   logic [1:0] rise_o;
   logic [1:0] fall_o;

   input_conditioner #(
      .NUM_CH(2),
      .DEBOUNCE_CYCLES(D),
      .REPEAT_DELAY(RD),
      .REPEAT_PERIOD(RP)
   ) dut (
      .clock  (clock),
      .clear  (clear),
      .raw_i  (raw_i),
      .level_o(level_o),
      .rise_o (rise_o),
      .fall_o (fall_o)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] got,
                      input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   // Reference model: raw passes a two-sample delay line; the accepted
   // level flips once D+1 consecutive samples disagree with it.
   logic [1:0] dl0, dl1, m_lvl, m_rise, m_fall;
   int run [2];
   int hold [2];

   task automatic model(input logic c, input logic [1:0] r);
      logic smp;
      logic stay;
      if (c) begin
         dl0 = '0; dl1 = '0; m_lvl = '0; m_rise = '0; m_fall = '0;
         for (int k = 0; k < 2; k++) begin run[k] = 0; hold[k] = 0; end
      end else begin
         for (int k = 0; k < 2; k++) begin
            smp = dl1[k];
            m_rise[k] = 1'b0;
            m_fall[k] = 1'b0;
            stay = m_lvl[k] && run[k] == 0 && smp;
            if (smp != m_lvl[k]) begin
               run[k]++;
               if (run[k] == D + 1) begin
                  m_lvl[k] = smp;
                  if (smp) m_rise[k] = 1'b1;
                  else m_fall[k] = 1'b1;
                  run[k] = 0;
               end
            end else begin
               run[k] = 0;
            end
`ifdef INPUT_COND_REPEAT_EN
            if (stay) begin
               hold[k]++;
               if (hold[k] == RD || (hold[k] > RD && (hold[k] - RD) % RP == 0))
                  m_rise[k] = 1'b1;
            end else begin
               hold[k] = 0;
            end
`else
            if (stay) hold[k]++;
            else hold[k] = 0;
`endif
         end
         dl1 = dl0;
         dl0 = r;
      end
   endtask

   task automatic tick;
      logic c;
      logic [1:0] r;
      c = clear;
      r = raw_i;
      @(posedge clock);
      #1;
      model(c, r);
   endtask

   // Per-cycle stimulus {clear, raw} and recorded output maps (bit = cycle).
   logic [2:0]  stim [64];
   logic [63:0] mr0, mr1, mf0, mf1, ml0;

   task automatic watch(input int n);
      mr0 = '0; mr1 = '0; mf0 = '0; mf1 = '0; ml0 = '0;
      for (int c = 0; c < n; c++) begin
         {clear, raw_i} = stim[c];
         tick();
         mr0[c+1] = rise_o[0];
         mr1[c+1] = rise_o[1];
         mf0[c+1] = fall_o[0];
         mf1[c+1] = fall_o[1];
         ml0[c+1] = level_o[0];
      end
   endtask

   task automatic do_reset;
      clear = 1'b1;
      raw_i = 2'b00;
      tick();
      tick();
      clear = 1'b0;
      for (int i = 0; i < 3; i++) tick();
   endtask

   function automatic logic [63:0] bit_at(input int c);
      logic [63:0] one;
      one = 64'd1;
      return one << c;
   endfunction

   typedef struct {
      int          hold;
      logic [63:0] exp_rise;
      logic [63:0] exp_fall;
   } vec_t;

   vec_t tbl [5];
   logic [63:0] e_lvl;
   logic [63:0] e_rep;
   int ha [2];

   initial begin
      tbl[0] = '{4, 64'd0, 64'd0};
      tbl[1] = '{5, 64'd1 << 7, 64'd1 << 12};
      tbl[2] = '{1, 64'd0, 64'd0};
      tbl[3] = '{6, 64'd1 << 7, 64'd1 << 13};
      tbl[4] = '{3, 64'd0, 64'd0};

      // Reset with both pins high, then release.
      clear = 1'b1;
      raw_i = 2'b11;
      tick();
      tick();
      chk("reset_outputs", {58'd0, level_o, rise_o, fall_o}, 64'd0);
      for (int c = 0; c < 12; c++) stim[c] = 3'b011;
      watch(12);
      chk("release_rise0", mr0, bit_at(7));
      chk("release_rise1", mr1, bit_at(7));

      // Long press with drop.
      do_reset();
      for (int c = 0; c < 45; c++) stim[c] = (c < 30) ? 3'b001 : 3'b000;
      watch(45);
      e_lvl = (bit_at(37) - 64'd1) & ~(bit_at(7) - 64'd1);
      chk("press_rise", mr0, bit_at(7));
      chk("press_level", ml0, e_lvl);
      chk("press_fall", mf0, bit_at(37));

      // Pulse-width acceptance table.
      for (int i = 0; i < 5; i++) begin
         do_reset();
         for (int c = 0; c < 25; c++)
            stim[c] = (c < tbl[i].hold) ? 3'b001 : 3'b000;
         watch(25);
         chk($sformatf("width%0d_rise", tbl[i].hold), mr0, tbl[i].exp_rise);
         chk($sformatf("width%0d_fall", tbl[i].hold), mf0, tbl[i].exp_fall);
      end

      // Bounce on channel 1.
      do_reset();
      for (int c = 0; c < 30; c++)
         stim[c] = (c >= 12 || (c / 2) % 2 == 0) ? 3'b010 : 3'b000;
      watch(30);
      chk("bounce_rise", mr1, bit_at(19));
      chk("bounce_fall", mf1, 64'd0);

      // Simultaneous rise on both channels.
      do_reset();
      for (int c = 0; c < 12; c++) stim[c] = 3'b011;
      watch(12);
      chk("simul_rise0", mr0, bit_at(7));
      chk("simul_rise1", mr1, bit_at(7));

      // Clear mid-debounce with pin released: no pulse, then fresh debounce.
      do_reset();
      for (int c = 0; c < 20; c++)
         stim[c] = (c < 4) ? 3'b001 : (c == 4) ? 3'b100 : 3'b000;
      watch(20);
      chk("midclr_norise", mr0 | mf0, 64'd0);
      for (int c = 0; c < 15; c++) stim[c] = (c < 5) ? 3'b001 : 3'b000;
      watch(15);
      chk("midclr_fresh", mr0, bit_at(7));

      // Clear mid-debounce with pin held: exactly one rise after release.
      do_reset();
      for (int c = 0; c < 25; c++) stim[c] = (c == 4) ? 3'b101 : 3'b001;
      watch(25);
      chk("midclr_held", mr0, bit_at(12));

      // Held press: auto-repeat when built in.
      do_reset();
      for (int c = 0; c < 41; c++) stim[c] = (c < 40) ? 3'b001 : 3'b000;
      watch(41);
`ifdef INPUT_COND_REPEAT_EN
      e_rep = bit_at(7) | bit_at(17) | bit_at(22) | bit_at(27)
            | bit_at(32) | bit_at(37);
`else
      e_rep = bit_at(7);
`endif
      chk("repeat_rise", mr0, e_rep);

      // Randomized stimulus against the model.
      clear = 1'b1;
      raw_i = 2'b00;
      tick();
      ha[0] = 0;
      ha[1] = 0;
      for (int i = 0; i < 3000; i++) begin
         clear = ($urandom_range(0, 299) == 0);
         for (int k = 0; k < 2; k++) begin
            if (ha[k] == 0) begin
               raw_i[k] = ~raw_i[k];
               ha[k] = $urandom_range(1, 12);
               if ($urandom_range(0, 9) == 0) ha[k] = $urandom_range(14, 30);
            end
            ha[k]--;
         end
         tick();
         chk("rand_level", {62'd0, level_o}, {62'd0, m_lvl});
         chk("rand_rise", {62'd0, rise_o}, {62'd0, m_rise});
         chk("rand_fall", {62'd0, fall_o}, {62'd0, m_fall});
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
